// File: rtl/irq_dma_arbiter_pkg.sv
// Shared CPU-side types and constants for the interrupt/DMA arbiter.
//   e_arb_state      : DMA bus-hold FSM states
//   NUM_IRQ          : number of external IRQ lines (one z_bus byte)
//   INT_VECTOR_SHIFT : left shift applied to the IRQ index in int_vector
package pa_cpu;

  localparam int NUM_IRQ          = 8;
  localparam int INT_VECTOR_SHIFT = 1;
  localparam int IRQ_IDX_W        = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DMA_WAIT,
    ARB_DMA_HOLD
  } e_arb_state;

endpackage

// File: rtl/irq_dma_arbiter_sync_edge_detect.sv
// Multi-flop synchroniser with a registered rising-edge pulse.
//   clk    : system clock
//   arst_n : asynchronous reset, active-low
//   d      : asynchronous input
//   level  : synchronised level (SYNC_STAGES clocks after d)
//   rise   : one-clock pulse when level goes 0 -> 1
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/irq_dma_arbiter.sv
// IRQ / DMA arbiter in front of the microcode sequencer.
// Latches IRQ rising edges into pending, applies the mask register, encodes
// the winning IRQ into a vector byte on ack and runs the DMA bus-hold
// handshake. DMA always takes precedence over interrupts.
//   clk, arst_n          : clock, asynchronous active-low reset
//   irq_in[7:0]          : async IRQ lines, rising-edge triggered
//   dma_req_in           : async DMA request, level
//   z_bus[7:0]           : mask write data
//   ctrl_irq_masks_wrt   : active-low mask load strobe
//   ctrl_int_ack         : accept highest-priority masked IRQ
//   ctrl_clear_all_ints  : clear all pending bits
//   ctrl_int_eoi         : end of service
//   ctrl_dma_grant       : bus parked for DMA
//   int_pending          : masked IRQ waiting, none in service, no DMA
//   dma_req / dma_ack    : DMA handshake to sequencer / DMA master
//   int_vector           : {4'b0, idx, 1'b0} of last acked IRQ
//   irq_masks            : mask register, 1 = enabled
//   irq_status           : raw pending bits
module irq_dma_arbiter
  import pa_cpu::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               dma_req_in,
  input  logic [7:0]         z_bus,
  input  logic               ctrl_irq_masks_wrt,
  input  logic               ctrl_int_ack,
  input  logic               ctrl_clear_all_ints,
  input  logic               ctrl_int_eoi,
  input  logic               ctrl_dma_grant,
  output logic               int_pending,
  output logic               dma_req,
  output logic               dma_ack,
  output logic [7:0]         int_vector,
  output logic [7:0]         irq_masks,
  output logic [7:0]         irq_status
);

  // Bit 0 has the highest priority.
  function automatic logic [IRQ_IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IRQ_IDX_W'(i);
    end
  endfunction

  logic [NUM_IRQ-1:0]   irq_rise;
  logic [NUM_IRQ-1:0]   irq_lvl_unused;
  logic                 dma_req_s;
  logic                 dma_rise_unused;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   pending_nxt;
  logic [NUM_IRQ-1:0]   masked;
  logic                 in_service;
  logic                 ack_fire;
  logic [IRQ_IDX_W-1:0] ack_idx;
  e_arb_state           state;
  e_arb_state           state_nxt;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq_sync
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .d      (irq_in[i]),
      .level  (irq_lvl_unused[i]),
      .rise   (irq_rise[i])
    );
  end

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dma_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (dma_req_in),
    .level  (dma_req_s),
    .rise   (dma_rise_unused)
  );

  // Ack uses the mask value before any same-cycle mask write.
  assign masked   = pending & irq_masks;
  assign ack_fire = ctrl_int_ack & (|masked);
  assign ack_idx  = lowest_idx(masked);

  // Ordering gives the priorities: a new edge re-sets a bit being acked,
  // and clear_all overrides everything including new edges.
  always_comb begin
    pending_nxt = pending;
    if (ack_fire) pending_nxt[ack_idx] = 1'b0;
    pending_nxt = pending_nxt | irq_rise;
    if (ctrl_clear_all_ints) pending_nxt = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pending    <= '0;
      irq_masks  <= '0;
      int_vector <= '0;
      in_service <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (!ctrl_irq_masks_wrt) irq_masks <= z_bus;
      if (ack_fire) begin
        int_vector <= 8'({5'b0, ack_idx}) << INT_VECTOR_SHIFT;
        in_service <= 1'b1;
      end else if (ctrl_int_eoi) begin
        in_service <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:     if (dma_req_s) state_nxt = ARB_DMA_WAIT;
      ARB_DMA_WAIT: begin
        // A withdrawn request beats a late grant: no ack is ever issued.
        if (!dma_req_s)          state_nxt = ARB_IDLE;
        else if (ctrl_dma_grant) state_nxt = ARB_DMA_HOLD;
      end
      ARB_DMA_HOLD: if (!dma_req_s) state_nxt = ARB_IDLE;
      default:      state_nxt = ARB_IDLE;
    endcase
  end

  assign dma_req     = (state == ARB_DMA_WAIT);
  assign dma_ack     = (state == ARB_DMA_HOLD);
  assign irq_status  = pending;
  assign int_pending = (|masked) & ~in_service & (state == ARB_IDLE) & ~dma_req_s;

endmodule

// File: tb/tb_irq_dma_arbiter.sv
module tb_irq_dma_arbiter;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] irq_in;
  logic       dma_req_in;
  logic [7:0] z_bus;
  logic       ctrl_irq_masks_wrt;
  logic       ctrl_int_ack;
  logic       ctrl_clear_all_ints;
  logic       ctrl_int_eoi;
  logic       ctrl_dma_grant;
  logic       int_pending;
  logic       dma_req;
  logic       dma_ack;
  logic [7:0] int_vector;
  logic [7:0] irq_masks;
  logic [7:0] irq_status;

  irq_dma_arbiter dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .irq_in              (irq_in),
    .dma_req_in          (dma_req_in),
    .z_bus               (z_bus),
    .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
    .ctrl_int_ack        (ctrl_int_ack),
    .ctrl_clear_all_ints (ctrl_clear_all_ints),
    .ctrl_int_eoi        (ctrl_int_eoi),
    .ctrl_dma_grant      (ctrl_dma_grant),
    .int_pending         (int_pending),
    .dma_req             (dma_req),
    .dma_ack             (dma_ack),
    .int_vector          (int_vector),
    .irq_masks           (irq_masks),
    .irq_status          (irq_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] status;
    logic [7:0] masks;
    logic [7:0] vec;
    logic       ip;
    logic       dreq;
    logic       dack;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Stimulus for the next edge; pulse controls self-clear after each step.
  logic [7:0] s_irq, s_z;
  logic       s_dma, s_wrt, s_ack, s_clr, s_eoi, s_grant;

  // Reference model: architectural state plus a time history of the raw
  // inputs (index k = value presented k edges ago).
  logic [7:0] m_pend, m_mask, m_vec;
  logic       m_insvc, m_dma_wait, m_dma_own;
  logic [7:0] irq_hist[3];
  logic       dma_hist[3];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_vec = '0;
    m_insvc = 1'b0; m_dma_wait = 1'b0; m_dma_own = 1'b0;
    for (int k = 0; k < 3; k++) begin
      irq_hist[k] = '0;
      dma_hist[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [7:0] rise, masked, np;
    logic       dma_s;
    int         idx;
    exp_t       e;
    // An IRQ edge is seen once the line has been high for two sampled
    // edges after being low; the DMA level lags by two edges.
    rise   = irq_hist[1] & ~irq_hist[2];
    dma_s  = dma_hist[1];
    masked = m_pend & m_mask;
    np     = m_pend;
    if (s_ack && masked != 8'h00) begin
      idx = 0;
      while (!masked[idx]) idx++;
      np[idx] = 1'b0;
      m_vec   = 8'(idx * 2);
      m_insvc = 1'b1;
    end else if (s_eoi) begin
      m_insvc = 1'b0;
    end
    np = np | rise;
    if (s_clr) np = 8'h00;
    m_pend = np;
    if (!s_wrt) m_mask = s_z;
    if (m_dma_own) begin
      if (!dma_s) m_dma_own = 1'b0;
    end else if (m_dma_wait) begin
      if (!dma_s) m_dma_wait = 1'b0;
      else if (s_grant) begin
        m_dma_wait = 1'b0;
        m_dma_own  = 1'b1;
      end
    end else if (dma_s) begin
      m_dma_wait = 1'b1;
    end
    irq_hist[2] = irq_hist[1]; irq_hist[1] = irq_hist[0]; irq_hist[0] = s_irq;
    dma_hist[2] = dma_hist[1]; dma_hist[1] = dma_hist[0]; dma_hist[0] = s_dma;
    e.status = m_pend;
    e.masks  = m_mask;
    e.vec    = m_vec;
    e.dreq   = m_dma_wait;
    e.dack   = m_dma_own;
    e.ip     = (|(m_pend & m_mask)) && !m_insvc && !m_dma_wait && !m_dma_own && !dma_hist[1];
    sbq.push_back(e);
  endtask

  task automatic step();
    irq_in              = s_irq;
    dma_req_in          = s_dma;
    z_bus               = s_z;
    ctrl_irq_masks_wrt  = s_wrt;
    ctrl_int_ack        = s_ack;
    ctrl_clear_all_ints = s_clr;
    ctrl_int_eoi        = s_eoi;
    ctrl_dma_grant      = s_grant;
    @(posedge clk);
    model_edge();
    #1;
    s_ack = 1'b0; s_clr = 1'b0; s_eoi = 1'b0; s_grant = 1'b0; s_wrt = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_mask(input logic [7:0] m);
    s_z = m; s_wrt = 1'b0; step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".irq_status"}, irq_status, 8'h00);
    chk({tag, ".irq_masks"},  irq_masks,  8'h00);
    chk({tag, ".int_vector"}, int_vector, 8'h00);
    chk({tag, ".int_pending"}, {7'b0, int_pending}, 8'h00);
    chk({tag, ".dma_req"},    {7'b0, dma_req},    8'h00);
    chk({tag, ".dma_ack"},    {7'b0, dma_ack},    8'h00);
  endtask

  // Monitor: compares each registered output set against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("irq_status",  irq_status,  e.status);
        chk("irq_masks",   irq_masks,   e.masks);
        chk("int_vector",  int_vector,  e.vec);
        chk("int_pending", {7'b0, int_pending}, {7'b0, e.ip});
        chk("dma_req",     {7'b0, dma_req},     {7'b0, e.dreq});
        chk("dma_ack",     {7'b0, dma_ack},     {7'b0, e.dack});
      end
    end
  end

  initial begin
    s_irq = '0; s_z = '0; s_dma = 1'b0; s_wrt = 1'b1;
    s_ack = 1'b0; s_clr = 1'b0; s_eoi = 1'b0; s_grant = 1'b0;
    irq_in = '0; dma_req_in = 1'b0; z_bus = '0; ctrl_irq_masks_wrt = 1'b1;
    ctrl_int_ack = 1'b0; ctrl_clear_all_ints = 1'b0; ctrl_int_eoi = 1'b0;
    ctrl_dma_grant = 1'b0;
    model_reset();
    arst_n = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // Single IRQ on line 5, ack, eoi.
    set_mask(8'hFF);
    s_irq = 8'h20; steps(3);
    s_irq = 8'h00; step();
    s_ack = 1'b1; steps(3);
    s_eoi = 1'b1; steps(2);

    // Two simultaneous edges, priority to the lower index.
    s_irq = 8'h44; steps(4);
    s_irq = 8'h00; s_ack = 1'b1; step();
    s_eoi = 1'b1; step();
    s_ack = 1'b1; step();
    s_eoi = 1'b1; step();

    // Masked bit latches but does not raise int_pending until enabled.
    set_mask(8'h00);
    s_irq = 8'h02; steps(4);
    s_irq = 8'h00; step();
    set_mask(8'h02); steps(2);
    s_ack = 1'b1; step();
    s_eoi = 1'b1; step();
    set_mask(8'hFF);

    // DMA takes priority over a pending IRQ, then IRQ resurfaces.
    s_irq = 8'h01; steps(4);
    s_irq = 8'h00; s_dma = 1'b1; steps(4);
    s_grant = 1'b1; steps(4);
    s_dma = 1'b0; steps(4);
    s_ack = 1'b1; step();
    s_eoi = 1'b1; step();

    // Request withdrawn before grant, plus grant while idle.
    s_dma = 1'b1; steps(3);
    s_dma = 1'b0; steps(3);
    s_grant = 1'b1; steps(2);

    // clear_all on the same edge as a new rise on line 3.
    s_irq = 8'h08; steps(2);
    s_clr = 1'b1; steps(2);
    s_irq = 8'h00; steps(2);

    // Ack on line 4 while its edge recurs: bit stays set.
    s_irq = 8'h10; steps(4);
    s_irq = 8'h00; steps(2);
    s_irq = 8'h10; steps(2);
    s_ack = 1'b1; steps(2);
    s_eoi = 1'b1; s_clr = 1'b1; s_irq = 8'h00; steps(3);

    // Ack together with a mask write and eoi: old mask, in_service stays.
    s_irq = 8'h81; steps(4);
    s_irq = 8'h00; s_ack = 1'b1; s_eoi = 1'b1; s_z = 8'h80; s_wrt = 1'b0; steps(2);
    s_eoi = 1'b1; steps(2);
    s_ack = 1'b1; s_eoi = 1'b1; step();
    set_mask(8'hFF);

    // Async reset while holding the bus with every IRQ pending.
    s_clr = 1'b1; s_irq = 8'h00; steps(3);
    s_irq = 8'hFF; s_dma = 1'b1; steps(4);
    s_grant = 1'b1; steps(3);
    @(negedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    s_irq = 8'h00; s_dma = 1'b0;
    irq_in = 8'h00; dma_req_in = 1'b0;
    #1;
    arst_n = 1'b1;
    set_mask(8'hFF);

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      s_irq   = s_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 19) == 0) s_dma = ~s_dma;
      s_ack   = ($urandom_range(0, 3) == 0);
      s_eoi   = ($urandom_range(0, 4) == 0);
      s_clr   = ($urandom_range(0, 39) == 0);
      s_grant = ($urandom_range(0, 2) == 0);
      s_wrt   = ($urandom_range(0, 14) != 0);
      s_z     = 8'($urandom);
      step();
    end

    for (int k = 0; k < 10; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
